// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier sequencer.
//   state_e   : sequencer states
//   AU_ADD/SUB: encodings of the external add/sub unit control bit
//   W_DEFAULT : default operand width
package booth_pkg;

    localparam int W_DEFAULT = 4;

    localparam logic AU_ADD = 1'b0;
    localparam logic AU_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        WAIT,
        SHIFT,
        DONE
    } state_e;

endpackage

// File: rtl/booth_shreg.sv
// Booth working register {sgn, A, Q, q_1}.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : clear A/q_1/sgn and load Q from mlr_i
//   acc_we_i   : write A from acc_i
//   sgn_we_i   : write the saved sign bit from sgn_i
//   shift_i    : arithmetic right shift of {A,Q,q_1}, sgn feeds the MSB
//   acc_o, mlr_o, q1_o : current A, Q and q_1
module booth_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] mlr_i,
    input  logic         acc_we_i,
    input  logic [W-1:0] acc_i,
    input  logic         sgn_we_i,
    input  logic         sgn_i,
    input  logic         shift_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] mlr_o,
    output logic         q1_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] mlr_q;
    logic         q1_q;
    logic         sgn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            mlr_q <= '0;
            q1_q  <= 1'b0;
            sgn_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            mlr_q <= mlr_i;
            q1_q  <= 1'b0;
            sgn_q <= 1'b0;
        end else if (shift_i) begin
            // sgn is the true sign of the (W+1)-bit partial sum, so an
            // add/sub that overflowed W bits still shifts in correctly.
            {acc_q, mlr_q, q1_q} <= {sgn_q, acc_q, mlr_q};
        end else begin
            if (acc_we_i) acc_q <= acc_i;
            if (sgn_we_i) sgn_q <= sgn_i;
        end
    end

    assign acc_o = acc_q;
    assign mlr_o = mlr_q;
    assign q1_o  = q1_q;

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencer for a radix-2 Booth signed multiplier using an external,
// shareable W-bit registered add/sub unit.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request, sampled only in IDLE
//   multiplicand/multiplier: signed operands captured on accept
//   busy                  : high in every state except IDLE
//   done                  : one-cycle pulse, product valid
//   product               : signed 2W-bit result, held until replaced
//   au_a, au_b, au_ctrl   : operands / op select to the add/sub unit
//   au_o                  : add/sub result, one cycle after operands
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product,
    output logic [W-1:0]   au_a,
    output logic [W-1:0]   au_b,
    output logic           au_ctrl,
    input  logic [W-1:0]   au_o
);

    localparam int CW = $clog2(W) + 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     m_q;
    logic [2*W-1:0]   prod_q;

    logic [W-1:0]     acc;
    logic [W-1:0]     mlr;
    logic             q1;
    logic             load;
    logic             shift;
    logic             acc_we;
    logic             sgn_we;
    logic             sgn_new;
    logic             ovf;

    booth_shreg #(.W(W)) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .mlr_i    (multiplier),
        .acc_we_i (acc_we),
        .acc_i    (au_o),
        .sgn_we_i (sgn_we),
        .sgn_i    (sgn_new),
        .shift_i  (shift),
        .acc_o    (acc),
        .mlr_o    (mlr),
        .q1_o     (q1)
    );

    // Signed overflow of the W-bit result; in WAIT the op is a subtract
    // exactly when Q[0]=1 (pair 10).
    always_comb begin
        if (mlr[0]) ovf = (acc[W-1] != m_q[W-1]) && (au_o[W-1] != acc[W-1]);
        else        ovf = (acc[W-1] == m_q[W-1]) && (au_o[W-1] != acc[W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load)            m_q    <= multiplicand;
            if (state_q == DONE) prod_q <= {acc, mlr};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        acc_we  = 1'b0;
        sgn_we  = 1'b0;
        sgn_new = acc[W-1];
        au_ctrl = AU_ADD;
        done    = 1'b0;
        busy    = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = CW'(W);
                    state_d = EVAL;
                end
            end
            EVAL: begin
                unique case ({mlr[0], q1})
                    2'b01: begin
                        au_ctrl = AU_ADD;
                        state_d = WAIT;
                    end
                    2'b10: begin
                        au_ctrl = AU_SUB;
                        state_d = WAIT;
                    end
                    default: begin
                        sgn_we  = 1'b1;
                        sgn_new = acc[W-1];
                        state_d = SHIFT;
                    end
                endcase
            end
            WAIT: begin
                // Hold the op select the unit registered on entry.
                au_ctrl = mlr[0] ? AU_SUB : AU_ADD;
                acc_we  = 1'b1;
                sgn_we  = 1'b1;
                sgn_new = au_o[W-1] ^ ovf;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift   = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? DONE : EVAL;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign au_a = acc;
    assign au_b = m_q;
    // The finished result is presented directly in DONE and held in
    // prod_q afterwards, so the output never tracks the working register.
    assign product = (state_q == DONE) ? {acc, mlr} : prod_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;
    logic [3:0] au_a;
    logic [3:0] au_b;
    logic       au_ctrl;
    logic [3:0] au_o = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External add/sub unit: one-cycle registered latency.
    always_ff @(posedge clk) au_o <= au_ctrl ? (au_a - au_b) : (au_a + au_b);

    booth_seq_ctrl #(.W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .au_a         (au_a),
        .au_b         (au_b),
        .au_ctrl      (au_ctrl),
        .au_o         (au_o)
    );

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] p;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Cycles from accept edge to done: 1 + (3 per add/sub step, 2 per no-op step).
    function automatic int booth_lat(input logic [3:0] q);
        int   l;
        logic prev;
        l = 1;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            l += (q[i] != prev) ? 3 : 2;
            prev = q[i];
        end
        return l;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle following DONE, so consecutive calls are back-to-back.
    task automatic run_op(input logic [3:0] m, input logic [3:0] q, input logic [7:0] p,
                          input int exp_lat, input string nm, input bit extra,
                          output logic [31:0] trace);
        int lat;
        int ndone;
        bit busy_bad;
        bit fin;
        lat = 0;
        ndone = 0;
        busy_bad = 0;
        fin = 0;
        trace = '0;
        multiplicand = m;
        multiplier = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k < 32) trace[k] = au_ctrl;
            if (k == 1) check({nm, " au_b"}, 32'(au_b), 32'(m));
            if (extra && k == 3) begin
                start = 1'b1;
                multiplicand = ~m;
                multiplier = ~q;
            end
            if (extra && k == 5) start = 1'b0;
            if (lat == 0 && !busy) busy_bad = 1;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = k;
                    check({nm, " product"}, 32'(product), 32'(p));
                end
            end
            if (lat != 0 && k == lat + 1) begin
                check({nm, " busy_after"}, 32'(busy), 32'd0);
                check({nm, " done_after"}, 32'(done), 32'd0);
                check({nm, " product_held"}, 32'(product), 32'(p));
                fin = 1;
                break;
            end
            @(negedge clk);
        end
        if (!fin) check({nm, " timeout"}, 32'd0, 32'd1);
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " done_count"}, 32'(ndone), 32'd1);
        check({nm, " busy_during"}, 32'(busy_bad), 32'd0);
        $display("op %s M=%h Q=%h product=%h latency=%0d", nm, m, q, product, lat);
    endtask

    initial begin
        logic [31:0] tr;
        int          nd;
        logic signed [3:0] sm;
        logic signed [3:0] sq;
        int          pi;
        logic [7:0]  pe;

        vecs[0] = '{4'h3, 4'h2, 8'h06, 11};
        vecs[1] = '{4'h8, 4'h8, 8'h40, 10};
        vecs[2] = '{4'h8, 4'h7, 8'hC8, 11};
        vecs[3] = '{4'h0, 4'h5, 8'h00, 13};
        vecs[4] = '{4'h5, 4'h0, 8'h00, 9};
        vecs[5] = '{4'h7, 4'h7, 8'h31, 11};
        vecs[6] = '{4'hF, 4'hF, 8'h01, 10};
        vecs[7] = '{4'h8, 4'h1, 8'hF8, 11};
        vecs[8] = '{4'h7, 4'h8, 8'hC8, 10};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", 32'(product), 32'd0);
        check("reset au_a", 32'(au_a), 32'd0);
        check("reset au_b", 32'(au_b), 32'd0);
        check("reset au_ctrl", 32'(au_ctrl), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].m, vecs[i].q, vecs[i].p, vecs[i].lat, $sformatf("vec%0d", i), 1'b0, tr);
            // 3 x 2: no-op, SUB (held over EVAL+WAIT), ADD, no-op; au_ctrl low elsewhere.
            if (i == 0) check("vec0 au_ctrl_trace", tr, 32'h0000_0018);
        end

        // start pulsed while busy must be ignored
        run_op(4'h8, 4'h7, 8'hC8, 11, "start_while_busy", 1'b1, tr);

        // Asynchronous reset in SHIFT aborts the operation
        multiplicand = 4'h3;
        multiplier = 4'h2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort product", 32'(product), 32'd0);
        check("abort au_a", 32'(au_a), 32'd0);
        check("abort au_b", 32'(au_b), 32'd0);
        check("abort au_ctrl", 32'(au_ctrl), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort no_done", 32'(nd), 32'd0);
        $display("op abort_mid_shift done_pulses=%0d", nd);
        run_op(4'h3, 4'h2, 8'h06, 11, "after_abort", 1'b0, tr);

        // Exhaustive signed pairs, back-to-back
        for (int mi = 0; mi < 16; mi++) begin
            for (int qi = 0; qi < 16; qi++) begin
                sm = 4'(mi);
                sq = 4'(qi);
                pi = sm * sq;
                pe = pi[7:0];
                run_op(4'(mi), 4'(qi), pe, booth_lat(4'(qi)),
                       $sformatf("ex_%0d_%0d", sm, sq), 1'b0, tr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
